// File: rtl/ccd_timing_gen.sv
// rtl/ccd_timing_gen.sv - linear-CCD timing generator (CCD clocks, ADC strobe, pixel index)
module ccd_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int N_PIXELS = 3648,
  parameter int N_DUMMY  = 32,
  parameter int SH_WIDTH = 20,
  parameter int INT_W    = 24,
  parameter int IDX_W    = 12
) (
  input  logic             clk_in_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             mode_cont_i,
  input  logic [INT_W-1:0] int_time_i,
  input  logic             abort_i,
  output logic             ccd_clk_o,
  output logic             ccd_sh_o,
  output logic             ccd_rs_o,
  output logic             ccd_sp_o,
  output logic             adc_sample_o,
  output logic             pix_valid_o,
  output logic [IDX_W-1:0] pix_index_o,
  output logic             frame_done_o,
  output logic             busy_o
);

  localparam int N_TOT = N_DUMMY + N_PIXELS;
  localparam int PW    = $clog2(2 * CLK_DIV);
  localparam int CW_RO = $clog2(N_TOT + 1);
  localparam int CW_SH = $clog2(SH_WIDTH + 1);
  localparam int CW_A  = (CW_RO > CW_SH) ? CW_RO : CW_SH;
  localparam int CW    = (CW_A > INT_W) ? CW_A : INT_W;

  localparam logic [PW-1:0] PH_LAST = PW'(2 * CLK_DIV - 1);
  localparam logic [PW-1:0] PH_HIGH = PW'(CLK_DIV);
  localparam logic [PW-1:0] PH_RS   = PW'(CLK_DIV / 2);
  localparam logic [PW-1:0] PH_DONE = PW'(CLK_DIV + 1);

  typedef enum logic [1:0] {S_IDLE, S_SH, S_READOUT, S_INTEG} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [INT_W-1:0] int_q, int_d;
  logic             pending_q, pending_d;

  logic             ccd_clk_q, ccd_clk_d;
  logic             sh_q, sh_d;
  logic             rs_q, rs_d;
  logic             sp_q, sp_d;
  logic             adc_q, adc_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic             period_start;
  logic             readout_d;

  // phase_q is the divider phase of the cycle that follows the coming edge;
  // state_d/cnt_d describe that same cycle, so outputs are registered from them.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    int_d        = int_q;
    pending_d    = pending_q;
    period_start = (phase_q == '0);
    phase_d      = (phase_q == PH_LAST) ? '0 : phase_q + PW'(1);

    if (abort_i) begin
      state_d   = S_IDLE;
      pending_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (period_start && (pending_q || start_i)) begin
            state_d   = S_SH;
            cnt_d     = '0;
            pending_d = 1'b0;
          end else begin
            pending_d = pending_q | start_i;
          end
        end
        S_SH: begin
          if (period_start) begin
            if (cnt_q == CW'(SH_WIDTH - 1)) begin
              state_d = S_READOUT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        S_READOUT: begin
          if (period_start) begin
            if (cnt_q == CW'(N_TOT - 1)) begin
              cnt_d = '0;
              if (mode_cont_i) begin
                int_d   = int_time_i;
                state_d = (int_time_i == '0) ? S_SH : S_INTEG;
              end else begin
                state_d = S_IDLE;
              end
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        S_INTEG: begin
          if (period_start) begin
            if ((cnt_q + CW'(1)) == CW'(int_q)) begin
              state_d = S_SH;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    readout_d = (state_d == S_READOUT);
    ccd_clk_d = (phase_q < PH_HIGH);
    sh_d      = (state_d == S_SH);
    sp_d      = readout_d && (cnt_d == '0) && (phase_q < PH_HIGH);
    rs_d      = readout_d && (phase_q < PH_RS);
    adc_d     = readout_d && (phase_q == PH_HIGH);
    valid_d   = adc_d && (cnt_d >= CW'(N_DUMMY));
    idx_d     = valid_d ? IDX_W'(cnt_d - CW'(N_DUMMY)) : idx_q;
    done_d    = readout_d && (cnt_d == CW'(N_TOT - 1)) && (phase_q == PH_DONE);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_in_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      phase_q   <= '0;
      cnt_q     <= '0;
      int_q     <= '0;
      pending_q <= 1'b0;
      ccd_clk_q <= 1'b0;
      sh_q      <= 1'b0;
      rs_q      <= 1'b0;
      sp_q      <= 1'b0;
      adc_q     <= 1'b0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      int_q     <= int_d;
      pending_q <= pending_d;
      ccd_clk_q <= ccd_clk_d;
      sh_q      <= sh_d;
      rs_q      <= rs_d;
      sp_q      <= sp_d;
      adc_q     <= adc_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign ccd_clk_o    = ccd_clk_q;
  assign ccd_sh_o     = sh_q;
  assign ccd_rs_o     = rs_q;
  assign ccd_sp_o     = sp_q;
  assign adc_sample_o = adc_q;
  assign pix_valid_o  = valid_q;
  assign pix_index_o  = idx_q;
  assign frame_done_o = done_q;
  assign busy_o       = busy_q;

endmodule
